// File: rtl/serial_add_sequencer.sv
// Sequences a bit-serial adder datapath: operand load, WIDTH shifts, result collection.
// Latency: out_valid rises WIDTH+2 edges after acceptance (counting the accepting edge); holds until out_ready.
module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] load_a,
    output logic [WIDTH-1:0] load_b,
    output logic             reg_enable,
    output logic             carry_clear_n,
    input  logic             sum_bit,
    input  logic             carry_bit,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state         <= IDLE;
            load_a        <= '0;
            load_b        <= '0;
            result        <= '0;
            carry_out     <= 1'b0;
            count         <= '0;
            reg_enable    <= 1'b0;
            out_valid     <= 1'b0;
            in_ready      <= 1'b0;
            carry_clear_n <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    reg_enable    <= 1'b0;
                    carry_clear_n <= 1'b1;
                    if (in_ready && in_valid) begin
                        load_a        <= op_a;
                        load_b        <= op_b;
                        in_ready      <= 1'b0;
                        // Carry clear is registered, so it must drop on entry to LOAD.
                        carry_clear_n <= 1'b0;
                        state         <= LOAD;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    count         <= '0;
                    result        <= '0;
                    reg_enable    <= 1'b1;
                    carry_clear_n <= 1'b1;
                    state         <= SHIFT;
                end
                SHIFT: begin
                    result <= {sum_bit, result[WIDTH-1:1]};
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        // carry_bit here is the carry out of the MSB addition.
                        carry_out  <= carry_bit;
                        reg_enable <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    reg_enable    <= 1'b0;
                    out_valid     <= 1'b0;
                    in_ready      <= 1'b0;
                    carry_clear_n <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboarded bench for serial_add_sequencer with a behavioural serial-adder datapath (WIDTH 4 and 8).
module tb_serial_add_sequencer;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    // WIDTH=4 instance
    logic       in_valid4 = 1'b0, in_ready4, re4, ccn4, sum4, cy4, co4, ov4, ordy4 = 1'b1;
    logic [3:0] op_a4 = '0, op_b4 = '0, la4, lb4, res4, sa4, sb4;
    logic       cf4;
    // WIDTH=8 instance
    logic       in_valid8 = 1'b0, in_ready8, re8, ccn8, sum8, cy8, co8, ov8, ordy8 = 1'b1;
    logic [7:0] op_a8 = '0, op_b8 = '0, la8, lb8, res8, sa8, sb8;
    logic       cf8;

    serial_add_sequencer #(.WIDTH(4)) u4 (
        .clock(clock), .clear(clear), .in_valid(in_valid4), .in_ready(in_ready4),
        .op_a(op_a4), .op_b(op_b4), .load_a(la4), .load_b(lb4), .reg_enable(re4),
        .carry_clear_n(ccn4), .sum_bit(sum4), .carry_bit(cy4), .result(res4),
        .carry_out(co4), .out_valid(ov4), .out_ready(ordy4)
    );

    serial_add_sequencer #(.WIDTH(8)) u8 (
        .clock(clock), .clear(clear), .in_valid(in_valid8), .in_ready(in_ready8),
        .op_a(op_a8), .op_b(op_b8), .load_a(la8), .load_b(lb8), .reg_enable(re8),
        .carry_clear_n(ccn8), .sum_bit(sum8), .carry_bit(cy8), .result(res8),
        .carry_out(co8), .out_valid(ov8), .out_ready(ordy8)
    );

    // Datapath models: shift registers, full adder, carry flip-flop with async active-low clear.
    always @(posedge clock) begin
        if (!re4) begin sa4 <= la4; sb4 <= lb4; end
        else begin sa4 <= sa4 >> 1; sb4 <= sb4 >> 1; end
        if (!re8) begin sa8 <= la8; sb8 <= lb8; end
        else begin sa8 <= sa8 >> 1; sb8 <= sb8 >> 1; end
    end
    always @(posedge clock or negedge ccn4)
        if (!ccn4) cf4 <= 1'b0; else if (re4) cf4 <= cy4;
    always @(posedge clock or negedge ccn8)
        if (!ccn8) cf8 <= 1'b0; else if (re8) cf8 <= cy8;
    assign sum4 = sa4[0] ^ sb4[0] ^ cf4;
    assign cy4  = (sa4[0] & sb4[0]) | (cf4 & (sa4[0] ^ sb4[0]));
    assign sum8 = sa8[0] ^ sb8[0] ^ cf8;
    assign cy8  = (sa8[0] & sb8[0]) | (cf8 & (sa8[0] ^ sb8[0]));

    int total = 0, bad = 0;
    int cyc = 0;
    int last_xfer4 = -1;
    int ren4 = 0, ccl4 = 0, ren8 = 0;
    logic [4:0] q4[$];
    logic [8:0] q8[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (re4) ren4++;
        if (!ccn4) ccl4++;
        if (re8) ren8++;
    end

    // Monitor: pops the expected response on every output transfer.
    always @(negedge clock) begin
        logic [4:0] e4;
        logic [8:0] e8;
        if (!clear) chk("ready_valid_excl", {31'd0, in_ready4 & ov4}, 32'd0);
        if (ov4 && ordy4) begin
            if (q4.size() == 0) chk("q4_unexpected_out", 32'd1, 32'd0);
            else begin
                e4 = q4.pop_front();
                chk("result4", {28'd0, res4}, {28'd0, e4[3:0]});
                chk("carry4", {31'd0, co4}, {31'd0, e4[4]});
            end
            last_xfer4 = cyc;
        end
        if (ov8 && ordy8) begin
            if (q8.size() == 0) chk("q8_unexpected_out", 32'd1, 32'd0);
            else begin
                e8 = q8.pop_front();
                chk("result8", {24'd0, res8}, {24'd0, e8[7:0]});
                chk("carry8", {31'd0, co8}, {31'd0, e8[8]});
            end
        end
    end

    // Presents an operand pair until accepted; returns just after the accepting edge.
    task automatic accept4(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp,
                           output int acc_cyc);
        op_a4 = a; op_b4 = b; in_valid4 = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (in_ready4) begin
                q4.push_back(exp);
                acc_cyc = cyc;
                @(posedge clock); #1;
                return;
            end
        end
        chk("accept4_timeout", 32'd1, 32'd0);
    endtask

    // Counts edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic wait_valid4(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n++;
            if (ov4) return;
        end
        chk("out_valid4_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int acc, acc2, lat;

        // Reset state
        #1 clear = 1'b1;
        #2;
        chk("rst_in_ready", {31'd0, in_ready4}, 32'd0);
        chk("rst_out_valid", {31'd0, ov4}, 32'd0);
        chk("rst_reg_enable", {31'd0, re4}, 32'd0);
        chk("rst_carry_clear_n", {31'd0, ccn4}, 32'd0);
        chk("rst_result", {28'd0, res4}, 32'd0);
        chk("rst_load_a", {28'd0, la4}, 32'd0);
        chk("rst_out_valid8", {31'd0, ov8}, 32'd0);
        @(posedge clock); #1 clear = 1'b0;
        #1 chk("in_ready_held_after_release", {31'd0, in_ready4}, 32'd0);
        @(posedge clock); #1;
        chk("in_ready_first_edge", {31'd0, in_ready4}, 32'd1);
        chk("carry_clear_n_idle", {31'd0, ccn4}, 32'd1);

        // 5 + 3 = 8, latency and shift-cycle count
        ren4 = 0; ccl4 = 0;
        accept4(4'd5, 4'd3, {1'b0, 4'd8}, acc);
        in_valid4 = 1'b0;
        wait_valid4(lat);
        chk("latency", lat, 32'd6);
        @(posedge clock); #1;
        chk("reg_enable_cycles", ren4, 32'd4);

        // 15 + 1 = 0 carry 1, single carry clear cycle
        ren4 = 0; ccl4 = 0;
        accept4(4'd15, 4'd1, {1'b1, 4'd0}, acc);
        in_valid4 = 1'b0;
        wait_valid4(lat);
        @(posedge clock); #1;
        chk("carry_clear_cycles", ccl4, 32'd1);

        // Back-pressure: 6 + 7 = 13 held for 10 cycles
        ordy4 = 1'b0;
        accept4(4'd6, 4'd7, {1'b0, 4'd13}, acc);
        in_valid4 = 1'b0;
        wait_valid4(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            in_valid4 = i[0]; op_a4 = 4'd9; op_b4 = 4'd9;
            @(negedge clock);
            chk("bp_result", {28'd0, res4}, 32'd13);
            chk("bp_carry", {31'd0, co4}, 32'd0);
            chk("bp_out_valid", {31'd0, ov4}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready4}, 32'd0);
            chk("bp_load_a", {28'd0, la4}, 32'd6);
        end
        @(posedge clock); #1;
        in_valid4 = 1'b0; ordy4 = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("bp_release_out_valid", {31'd0, ov4}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready4}, 32'd1);

        // Clear during the second SHIFT cycle of 3 + 4
        @(posedge clock); #1;
        accept4(4'd3, 4'd4, {1'b0, 4'd7}, acc);
        in_valid4 = 1'b0;
        repeat (3) @(negedge clock);
        #1 clear = 1'b1;
        #1;
        chk("abort_reg_enable", {31'd0, re4}, 32'd0);
        chk("abort_out_valid", {31'd0, ov4}, 32'd0);
        chk("abort_result", {28'd0, res4}, 32'd0);
        chk("abort_carry_clear_n", {31'd0, ccn4}, 32'd0);
        q4.delete();
        @(posedge clock); #1 clear = 1'b0;
        accept4(4'd2, 4'd2, {1'b0, 4'd4}, acc);
        in_valid4 = 1'b0;
        wait_valid4(lat);
        @(posedge clock); #1;

        // Back-to-back with in_valid held high
        accept4(4'd1, 4'd1, {1'b0, 4'd2}, acc);
        accept4(4'd7, 4'd9, {1'b1, 4'd0}, acc2);
        in_valid4 = 1'b0;
        chk("b2b_accept_after_xfer", acc2, last_xfer4 + 1);
        wait_valid4(lat);
        repeat (2) @(posedge clock);
        #1;

        // WIDTH=8: 200 + 100 = 44 carry 1
        ren8 = 0;
        op_a8 = 8'd200; op_b8 = 8'd100; in_valid8 = 1'b1;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clock);
                if (in_ready8) begin
                    q8.push_back({1'b1, 8'd44});
                    got = 1'b1;
                    @(posedge clock); #1;
                end
            end
            if (!got) chk("accept8_timeout", 32'd1, 32'd0);
            in_valid8 = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clock);
                if (ov8) got = 1'b1;
            end
            if (!got) chk("out_valid8_timeout", 32'd1, 32'd0);
        end
        repeat (2) @(posedge clock);
        #1;
        chk("reg_enable_cycles8", ren8, 32'd8);

        chk("q4_drained", q4.size(), 32'd0);
        chk("q8_drained", q8.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
